// File: rtl/link_align_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : link_align_ctrl
// Purpose  : 8b/10b word-alignment controller. Hunts for a comma in the
//            deserialized 10b stream, slips the deserializer word boundary
//            one bit at a time until commas appear, verifies alignment over
//            several clean commas, then holds lock while tracking decode
//            errors and forcing a relock when they become too frequent.
// Ports    : byteclk      in   1   sole clock, rising edge
//            rst          in   1   synchronous active-high reset
//            word_valid   in   1   qualifies tenb_in / code_err / disp_err
//            tenb_in      in  10   current 10b word
//            code_err     in   1   decoder code error for tenb_in
//            disp_err     in   1   decoder disparity error for tenb_in
//            bitslip      out  1   one-cycle boundary shift request
//            slip_count   out  4   slips since last lock attempt (9 -> 0)
//            disp_load    out  1   one-cycle running-disparity load strobe
//            disp_value   out  1   disparity to load (1 = COMMA_P)
//            linkOk       out  1   aligned and locked
//            resync       out  1   one-cycle pulse on loss of lock
//            state        out  3   FSM state code (debug)
//            err_total    out 16   (LINK_ALIGN_ERRCNT_EN) saturating count of
//                                  errored words seen while locked
//            err_clr      in   1   (LINK_ALIGN_ERRCNT_EN) clear, beats increment
// Options  : define LINK_ALIGN_ERRCNT_EN to add the err_total/err_clr counter.
// Revision : 1.0 - initial release
// ============================================================================
module link_align_ctrl #(
  parameter int MISS_LIMIT = 16,
  parameter int SLIP_WAIT  = 8,
  parameter int COMMA_LOCK = 4,
  parameter int ERR_LIMIT  = 4,
  parameter int GOOD_RUN   = 64
) (
  input  logic       byteclk,
  input  logic       rst,
  input  logic       word_valid,
  input  logic [9:0] tenb_in,
  input  logic       code_err,
  input  logic       disp_err,
  output logic       bitslip,
  output logic [3:0] slip_count,
  output logic       disp_load,
  output logic       disp_value,
  output logic       linkOk,
  output logic       resync,
  output logic [2:0] state
`ifdef LINK_ALIGN_ERRCNT_EN
  ,
  input  logic        err_clr,
  output logic [15:0] err_total
`endif
);

  localparam logic [9:0] c_COMMA_P = 10'b1001111100;
  localparam logic [9:0] c_COMMA_N = 10'b0110000011;

  localparam int c_MISS_W  = $clog2(MISS_LIMIT + 1);
  localparam int c_WAIT_W  = $clog2(SLIP_WAIT + 1);
  localparam int c_COMMA_W = $clog2(COMMA_LOCK + 1);
  localparam int c_ERR_W   = $clog2(ERR_LIMIT + 1);
  localparam int c_GOOD_W  = $clog2(GOOD_RUN + 1);

  localparam logic [c_MISS_W-1:0]  c_MISS_LIM  = c_MISS_W'(MISS_LIMIT);
  localparam logic [c_WAIT_W-1:0]  c_WAIT_LAST = c_WAIT_W'(SLIP_WAIT - 1);
  localparam logic [c_COMMA_W-1:0] c_COMMA_LIM = c_COMMA_W'(COMMA_LOCK);
  localparam logic [c_ERR_W-1:0]   c_ERR_LIM   = c_ERR_W'(ERR_LIMIT);
  localparam logic [c_GOOD_W-1:0]  c_GOOD_LIM  = c_GOOD_W'(GOOD_RUN);

  typedef enum logic [2:0] {
    HUNT   = 3'd0,
    SLIP   = 3'd1,
    VERIFY = 3'd2,
    LOCKED = 3'd3
  } state_t;

  state_t               r_state,      w_state_nxt;
  logic [c_MISS_W-1:0]  r_miss,       w_miss_nxt;
  logic [c_WAIT_W-1:0]  r_wait,       w_wait_nxt;
  logic [c_COMMA_W-1:0] r_comma,      w_comma_nxt;
  logic [c_ERR_W-1:0]   r_err,        w_err_nxt;
  logic [c_GOOD_W-1:0]  r_good,       w_good_nxt;
  logic [3:0]           r_slips,      w_slips_nxt;
  logic                 r_bitslip,    w_bitslip_nxt;
  logic                 r_disp_load,  w_disp_load_nxt;
  logic                 r_disp_value, w_disp_value_nxt;
  logic                 r_link_ok,    w_link_ok_nxt;
  logic                 r_resync,     w_resync_nxt;
  logic                 w_slip_req;

  logic w_is_comma_p;
  logic w_is_comma;
  logic w_bad;

  // Saturating increments; the FSM clears each counter on reaching its
  // limit, so saturation only guards against out-of-range parameters.
  logic [c_MISS_W-1:0]  w_miss_inc;
  logic [c_COMMA_W-1:0] w_comma_inc;
  logic [c_ERR_W-1:0]   w_err_inc;
  logic [c_GOOD_W-1:0]  w_good_inc;

  assign w_is_comma_p = (tenb_in == c_COMMA_P);
  assign w_is_comma   = w_is_comma_p || (tenb_in == c_COMMA_N);
  assign w_bad        = code_err || disp_err;

  assign w_miss_inc  = (&r_miss)  ? r_miss  : r_miss  + 1'b1;
  assign w_comma_inc = (&r_comma) ? r_comma : r_comma + 1'b1;
  assign w_err_inc   = (&r_err)   ? r_err   : r_err   + 1'b1;
  assign w_good_inc  = (&r_good)  ? r_good  : r_good  + 1'b1;

  always_comb begin
    w_state_nxt      = r_state;
    w_miss_nxt       = r_miss;
    w_wait_nxt       = r_wait;
    w_comma_nxt      = r_comma;
    w_err_nxt        = r_err;
    w_good_nxt       = r_good;
    w_slips_nxt      = r_slips;
    w_disp_value_nxt = r_disp_value;
    w_link_ok_nxt    = r_link_ok;
    w_bitslip_nxt    = 1'b0;
    w_disp_load_nxt  = 1'b0;
    w_resync_nxt     = 1'b0;
    w_slip_req       = 1'b0;

    case (r_state)
      HUNT: begin
        if (word_valid) begin
          if (w_is_comma) begin
            w_state_nxt      = VERIFY;
            w_comma_nxt      = c_COMMA_W'(1);
            w_miss_nxt       = '0;
            w_disp_load_nxt  = 1'b1;
            w_disp_value_nxt = w_is_comma_p;
          end else if (w_miss_inc == c_MISS_LIM) begin
            w_slip_req = 1'b1;
          end else begin
            w_miss_nxt = w_miss_inc;
          end
        end
      end

      // word_valid is deliberately ignored while the deserializer settles.
      SLIP: begin
        if (r_wait == c_WAIT_LAST) begin
          w_state_nxt = HUNT;
          w_wait_nxt  = '0;
        end else begin
          w_wait_nxt = r_wait + 1'b1;
        end
      end

      VERIFY: begin
        if (word_valid) begin
          // Errors take precedence over comma detection so a corrupted comma
          // never loads disparity in the same cycle as a slip.
          if (w_bad) begin
            w_slip_req = 1'b1;
          end else if (w_is_comma) begin
            w_disp_load_nxt  = 1'b1;
            w_disp_value_nxt = w_is_comma_p;
            w_miss_nxt       = '0;
            if (w_comma_inc == c_COMMA_LIM) begin
              w_state_nxt   = LOCKED;
              w_link_ok_nxt = 1'b1;
              w_slips_nxt   = 4'd0;
              w_comma_nxt   = '0;
            end else begin
              w_comma_nxt = w_comma_inc;
            end
          end else if (w_miss_inc == c_MISS_LIM) begin
            w_slip_req = 1'b1;
          end else begin
            w_miss_nxt = w_miss_inc;
          end
        end
      end

      LOCKED: begin
        if (word_valid) begin
          if (w_bad) begin
            w_good_nxt = '0;
            if (w_err_inc == c_ERR_LIM) begin
              w_state_nxt   = HUNT;
              w_resync_nxt  = 1'b1;
              w_link_ok_nxt = 1'b0;
              w_err_nxt     = '0;
              w_miss_nxt    = '0;
              w_comma_nxt   = '0;
            end else begin
              w_err_nxt = w_err_inc;
            end
          end else if (w_good_inc == c_GOOD_LIM) begin
            w_good_nxt = '0;
            w_err_nxt  = '0;
          end else begin
            w_good_nxt = w_good_inc;
          end
        end
      end

      default: begin
        w_state_nxt = HUNT;
      end
    endcase

    // Common bitslip action shared by HUNT and VERIFY.
    if (w_slip_req) begin
      w_bitslip_nxt = 1'b1;
      w_slips_nxt   = (r_slips == 4'd9) ? 4'd0 : r_slips + 4'd1;
      w_miss_nxt    = '0;
      w_comma_nxt   = '0;
      w_wait_nxt    = '0;
      w_state_nxt   = SLIP;
    end
  end

  always_ff @(posedge byteclk) begin
    if (rst) begin
      r_state      <= HUNT;
      r_miss       <= '0;
      r_wait       <= '0;
      r_comma      <= '0;
      r_err        <= '0;
      r_good       <= '0;
      r_slips      <= 4'd0;
      r_bitslip    <= 1'b0;
      r_disp_load  <= 1'b0;
      r_disp_value <= 1'b0;
      r_link_ok    <= 1'b0;
      r_resync     <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_miss       <= w_miss_nxt;
      r_wait       <= w_wait_nxt;
      r_comma      <= w_comma_nxt;
      r_err        <= w_err_nxt;
      r_good       <= w_good_nxt;
      r_slips      <= w_slips_nxt;
      r_bitslip    <= w_bitslip_nxt;
      r_disp_load  <= w_disp_load_nxt;
      r_disp_value <= w_disp_value_nxt;
      r_link_ok    <= w_link_ok_nxt;
      r_resync     <= w_resync_nxt;
    end
  end

  assign bitslip    = r_bitslip;
  assign slip_count = r_slips;
  assign disp_load  = r_disp_load;
  assign disp_value = r_disp_value;
  assign linkOk     = r_link_ok;
  assign resync     = r_resync;
  assign state      = r_state;

`ifdef LINK_ALIGN_ERRCNT_EN
  logic [15:0] r_err_total;

  always_ff @(posedge byteclk) begin
    if (rst || err_clr) begin
      r_err_total <= 16'd0;
    end else if ((r_state == LOCKED) && word_valid && w_bad && !(&r_err_total)) begin
      r_err_total <= r_err_total + 16'd1;
    end
  end

  assign err_total = r_err_total;
`endif

endmodule
`default_nettype wire

// File: tb/tb_link_align_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_link_align_ctrl
// Purpose  : Scoreboard bench for link_align_ctrl. Directed scenarios plus
//            randomized traffic; a reference model predicts every output
//            cycle, a monitor compares the DUT against the queued prediction.
// Revision : 1.0 - initial release
// ============================================================================
module tb_link_align_ctrl;

  localparam int MISS_LIMIT = 16;
  localparam int SLIP_WAIT  = 8;
  localparam int COMMA_LOCK = 4;
  localparam int ERR_LIMIT  = 4;
  localparam int GOOD_RUN   = 64;

  localparam logic [9:0] c_CP = 10'b1001111100;
  localparam logic [9:0] c_CN = 10'b0110000011;

  logic        byteclk = 1'b0;
  logic        rst = 1'b1;
  logic        word_valid = 1'b0;
  logic [9:0]  tenb_in = 10'd0;
  logic        code_err = 1'b0;
  logic        disp_err = 1'b0;
  logic        err_clr = 1'b0;
  logic        bitslip;
  logic [3:0]  slip_count;
  logic        disp_load;
  logic        disp_value;
  logic        linkOk;
  logic        resync;
  logic [2:0]  state;
`ifdef LINK_ALIGN_ERRCNT_EN
  logic [15:0] err_total;
`endif

  always #5 byteclk = ~byteclk;

  link_align_ctrl #(
    .MISS_LIMIT(MISS_LIMIT), .SLIP_WAIT(SLIP_WAIT), .COMMA_LOCK(COMMA_LOCK),
    .ERR_LIMIT(ERR_LIMIT), .GOOD_RUN(GOOD_RUN)
  ) dut (
    .byteclk(byteclk), .rst(rst), .word_valid(word_valid), .tenb_in(tenb_in),
    .code_err(code_err), .disp_err(disp_err), .bitslip(bitslip),
    .slip_count(slip_count), .disp_load(disp_load), .disp_value(disp_value),
    .linkOk(linkOk), .resync(resync), .state(state)
`ifdef LINK_ALIGN_ERRCNT_EN
    , .err_clr(err_clr), .err_total(err_total)
`endif
  );

  typedef struct packed {
    logic        bs;
    logic [3:0]  sc;
    logic        dl;
    logic        dv;
    logic        lok;
    logic        rs;
    logic [2:0]  st;
    logic [15:0] tot;
  } obs_t;

  obs_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  // ---------------- reference model (mode: 0 hunt,1 slip,2 verify,3 locked)
  int   m_mode, m_miss, m_commas, m_errs, m_good, m_wait, m_slips, m_tot;
  logic m_dv, m_lok;

  task automatic model_step(input logic r, input logic v, input logic [9:0] w,
                            input logic ce, input logic de, input logic clr,
                            output obs_t o);
    bit comma, bad, bs, dl, rs;
    comma = (w == c_CP) || (w == c_CN);
    bad   = ce || de;
    bs = 0; dl = 0; rs = 0;
    if (r) begin
      m_mode = 0; m_miss = 0; m_commas = 0; m_errs = 0; m_good = 0;
      m_wait = 0; m_slips = 0; m_tot = 0; m_dv = 0; m_lok = 0;
    end else begin
      if (clr) m_tot = 0;
      else if (m_mode == 3 && v && bad && m_tot < 65535) m_tot++;
      if (m_mode == 1) begin
        m_wait++;
        if (m_wait == SLIP_WAIT) m_mode = 0;
      end else if (v) begin
        if (m_mode == 0) begin
          if (comma) begin
            m_mode = 2; m_commas = 1; m_miss = 0; dl = 1; m_dv = (w == c_CP);
          end else begin
            m_miss++;
            if (m_miss == MISS_LIMIT) bs = 1;
          end
        end else if (m_mode == 2) begin
          if (bad) bs = 1;
          else if (comma) begin
            m_commas++; m_miss = 0; dl = 1; m_dv = (w == c_CP);
            if (m_commas == COMMA_LOCK) begin
              m_mode = 3; m_lok = 1; m_slips = 0; m_commas = 0;
              m_errs = 0; m_good = 0;
            end
          end else begin
            m_miss++;
            if (m_miss == MISS_LIMIT) bs = 1;
          end
        end else begin
          if (bad) begin
            m_errs++; m_good = 0;
            if (m_errs == ERR_LIMIT) begin
              rs = 1; m_lok = 0; m_mode = 0;
              m_errs = 0; m_miss = 0; m_commas = 0;
            end
          end else begin
            m_good++;
            if (m_good == GOOD_RUN) begin m_good = 0; m_errs = 0; end
          end
        end
        if (bs) begin
          m_slips = (m_slips + 1) % 10; m_miss = 0; m_commas = 0;
          m_wait = 0; m_mode = 1;
        end
      end
    end
    o.bs = bs; o.sc = 4'(m_slips); o.dl = dl; o.dv = m_dv; o.lok = m_lok;
    o.rs = rs; o.st = 3'(m_mode); o.tot = 16'(m_tot);
  endtask

  // ---------------- stimulus
  task automatic drive(input logic r, input logic v, input logic [9:0] w,
                       input logic ce, input logic de, input logic clr);
    obs_t e;
    @(negedge byteclk);
    rst = r; word_valid = v; tenb_in = w; code_err = ce; disp_err = de;
    err_clr = clr;
    model_step(r, v, w, ce, de, clr, e);
    q.push_back(e);
  endtask

  function automatic logic [9:0] noncomma();
    logic [9:0] w;
    w = 10'($urandom);
    while (w == c_CP || w == c_CN) w = 10'($urandom);
    return w;
  endfunction

  task automatic send(input logic [9:0] w, input logic ce, input logic de);
    drive(1'b0, 1'b1, w, ce, de, 1'b0);
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b0, 10'd0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, noncomma(), 1'b1, 1'b0, 1'b0);
  endtask

  task automatic lock_up();
    do_reset();
    for (int i = 0; i < COMMA_LOCK; i++) send(c_CP, 1'b0, 1'b0);
  endtask

  // ---------------- monitor
  initial begin
    obs_t a, e;
    forever begin
      @(posedge byteclk);
      #1;
      cyc++;
      if (q.size() > 0) begin
        e = q.pop_front();
        a.bs = bitslip; a.sc = slip_count; a.dl = disp_load; a.dv = disp_value;
        a.lok = linkOk; a.rs = resync; a.st = state;
`ifdef LINK_ALIGN_ERRCNT_EN
        a.tot = err_total;
`else
        a.tot = 16'd0;
        e.tot = 16'd0;
`endif
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL outputs cycle %0d: got bs=%b sc=%0d dl=%b dv=%b lok=%b rs=%b st=%0d tot=%0d, expected bs=%b sc=%0d dl=%b dv=%b lok=%b rs=%b st=%0d tot=%0d",
                   cyc, a.bs, a.sc, a.dl, a.dv, a.lok, a.rs, a.st, a.tot,
                   e.bs, e.sc, e.dl, e.dv, e.lok, e.rs, e.st, e.tot);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence
  initial begin
    // Lock on four COMMA_P words.
    lock_up();
    send(noncomma(), 1'b0, 1'b0);

    // Ten slips from HUNT; slip_count wraps 9 -> 0. Words during SLIP ignored.
    do_reset();
    for (int rep = 0; rep < 10; rep++) begin
      for (int i = 0; i < MISS_LIMIT; i++) send(noncomma(), 1'b0, 1'b0);
      for (int i = 0; i < SLIP_WAIT; i++) send(c_CN, 1'b0, 1'b0);
    end
    send(noncomma(), 1'b0, 1'b0);

    // VERIFY after two commas, then a code error (on a comma) -> slip.
    do_reset();
    send(c_CN, 1'b0, 1'b0);
    send(c_CP, 1'b0, 1'b0);
    send(c_CN, 1'b1, 1'b0);
    for (int i = 0; i < SLIP_WAIT + 1; i++) drive(1'b0, 1'b0, 10'd0, 1'b0, 1'b0, 1'b0);

    // Locked error handling: 3 errors, good run, 3 errors, then 4th loses lock.
    lock_up();
    for (int i = 0; i < 3; i++) send(noncomma(), 1'b1, 1'b0);
    for (int i = 0; i < GOOD_RUN; i++) send((i % 5 == 0) ? c_CP : noncomma(), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) send(noncomma(), 1'b0, 1'b1);
    drive(1'b0, 1'b0, 10'd0, 1'b1, 1'b1, 1'b0);
    send(c_CN, 1'b1, 1'b0);
    send(noncomma(), 1'b0, 1'b0);

    // Reset with a valid comma while locked.
    lock_up();
    drive(1'b1, 1'b1, c_CP, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 10'd0, 1'b0, 1'b0, 1'b0);

`ifdef LINK_ALIGN_ERRCNT_EN
    // Five errored words while locked, then clear together with an error.
    lock_up();
    for (int i = 0; i < 3; i++) send(noncomma(), 1'b1, 1'b0);
    for (int i = 0; i < GOOD_RUN; i++) send(noncomma(), 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) send(noncomma(), 1'b0, 1'b1);
    drive(1'b0, 1'b1, noncomma(), 1'b1, 1'b0, 1'b1);
    send(noncomma(), 1'b0, 1'b0);
`endif

    // Randomized traffic.
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      int sel;
      logic [9:0] w;
      sel = int'($urandom_range(0, 99));
      w = (sel < 25) ? c_CP : (sel < 45) ? c_CN : noncomma();
      drive(($urandom_range(0, 299) == 0), ($urandom_range(0, 9) < 8), w,
            ($urandom_range(0, 19) == 0), ($urandom_range(0, 29) == 0),
`ifdef LINK_ALIGN_ERRCNT_EN
            ($urandom_range(0, 199) == 0)
`else
            1'b0
`endif
      );
    end

    repeat (3) @(negedge byteclk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending predictions, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/link_align_ctrl.md
LINK_ALIGN_CTRL -- requirements
Module: link_align_ctrl

Interface
REQ-001 The block SHALL have parameters, one per line: name, default, meaning.
- MISS_LIMIT, 16: valid words without a comma before a bitslip is issued.
- SLIP_WAIT, 8: byteclk cycles to wait after a bitslip for the deserializer to settle.
- COMMA_LOCK, 4: consecutive clean commas needed to declare lock.
- ERR_LIMIT, 4: decode errors allowed in LOCKED before relock.
- GOOD_RUN, 64: consecutive clean words that clear the LOCKED error count.
REQ-002 The block SHALL have ports, one per line: name, direction, width, meaning.
- byteclk, in, 1: sole clock; all logic on its rising edge.
- rst, in, 1: synchronous, active-high reset.
- word_valid, in, 1: qualifies tenb_in, code_err and disp_err.
- tenb_in, in, 10: current 10b word from the deserializer.
- code_err, in, 1: decoder code error for tenb_in.
- disp_err, in, 1: decoder disparity error for tenb_in.
- bitslip, out, 1: one-cycle pulse that shifts the deserializer word boundary by one bit.
- slip_count, out, 4: number of slips since the last lock attempt, wrapping 9 to 0.
- disp_load, out, 1: one-cycle pulse that loads the decoder running disparity.
- disp_value, out, 1: disparity to load; 1 for COMMA_P, 0 for COMMA_N.
- linkOk, out, 1: link aligned and locked.
- resync, out, 1: one-cycle pulse when lock is lost.
- state, out, 3: current FSM state code, for debug.

Function
REQ-003 The commas SHALL be COMMA_P = 10'b1001111100 and COMMA_N = 10'b0110000011; "clean" means code_err=0 and disp_err=0.
REQ-004 The FSM states and codes SHALL be HUNT=0, SLIP=1, VERIFY=2, LOCKED=3; no other codes are reachable.
REQ-005 All outputs SHALL be registered, and each output SHALL reflect the word_valid cycle that caused it exactly 1 cycle later.
REQ-006 In HUNT, a valid comma SHALL cause: go to VERIFY, set comma_cnt=1, clear miss_cnt, and pulse disp_load with the matching disp_value.
REQ-007 In HUNT, a valid non-comma SHALL increment miss_cnt; the word that makes miss_cnt equal MISS_LIMIT SHALL cause: pulse bitslip, increment slip_count mod 10, clear miss_cnt, enter SLIP.
REQ-008 In SLIP, the FSM SHALL remain SLIP_WAIT cycles while ignoring word_valid, then return to HUNT.
REQ-009 In VERIFY, a valid clean comma SHALL increment comma_cnt and pulse disp_load; on reaching COMMA_LOCK it SHALL enter LOCKED, assert linkOk, and clear slip_count.
REQ-010 In VERIFY, any valid word with code_err or disp_err, or MISS_LIMIT valid words without a comma, SHALL pulse bitslip and enter SLIP.
REQ-011 In LOCKED, each valid errored word SHALL increment err_cnt and zero good_cnt; each valid clean word SHALL increment good_cnt, and reaching GOOD_RUN SHALL clear both counters.
REQ-012 In LOCKED, the error that makes err_cnt equal ERR_LIMIT SHALL pulse resync, deassert linkOk, and enter HUNT with all counters cleared (no bitslip).
REQ-013 In LOCKED, commas SHALL NOT pulse disp_load.
REQ-014 The block SHALL never assert bitslip and disp_load in the same cycle; an errored comma in VERIFY is treated as an error only.
REQ-015 Counters SHALL be sized to their parameter, SHALL saturate and never wrap, and no counter SHALL change while word_valid=0 except the SLIP wait counter.

Reset
REQ-016 While rst=1, the block SHALL set state=HUNT, bitslip=0, slip_count=0, disp_load=0, disp_value=0, linkOk=0, resync=0, and clear all internal counters.
REQ-017 rst SHALL take priority over word_valid in the same cycle; reset mid-SLIP or mid-LOCKED SHALL abort to HUNT without a resync pulse.

Configuration
REQ-018 With macro LINK_ALIGN_ERRCNT_EN defined, the block SHALL add ports err_total (out, 16, saturating count of valid errored words in LOCKED) and err_clr (in, 1, synchronous clear with priority over increment).
REQ-019 Without LINK_ALIGN_ERRCNT_EN, those ports and their logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-020 Bench SHALL cover the following directed scenarios, with default parameters unless stated:
- Reset then 4 valid COMMA_P words: disp_load/disp_value=1 on each, linkOk=1 one cycle after the 4th, state=3.
- 16 valid non-comma words: one bitslip pulse, slip_count=1, 8 SLIP cycles, then state=0; repeat 10 times, and slip_count wraps to 0.
- VERIFY after 2 commas, then a word with code_err=1: bitslip pulse and state=1, linkOk stays 0.
- LOCKED, 3 errors, 64 clean words, then 3 errors: linkOk stays 1; a 4th error: resync pulse, linkOk=0, state=0.
- rst=1 together with word_valid carrying a comma during LOCKED: all outputs reset, no disp_load, no resync.
- With LINK_ALIGN_ERRCNT_EN: 5 errors give err_total=5; err_clr together with an error gives err_total=0.
